// File: rtl/hazard_ctrl_pipe.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline.
// A three-entry scoreboard (EX/MEM/WB) drives stall, flush and operand
// bypass selects, and saturating counters track retirements, stalls and
// taken-branch flushes.
module hazard_ctrl_pipe #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter bit          FORWARDING     = 1'b1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      ex_branch_taken,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [1:0]                fwd_a_e,
  output logic [1:0]                fwd_b_e,
  output logic [CNT_WIDTH-1:0]      retired_cnt,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_X0   = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]                SEL_RF   = 2'b00;
  localparam logic [1:0]                SEL_WB   = 2'b01;
  localparam logic [1:0]                SEL_MEM  = 2'b10;

  // A source depends on a stage only if that stage really writes a non-x0 rd
  // and the consuming instruction actually reads the source.
  function automatic logic src_match(
    input logic                      valid,
    input logic                      regwrite,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic                      use_src
  );
    return valid && regwrite && (rd != REG_X0) && (rd == src) && use_src;
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 en
  );
    return (en && (cnt != CNT_MAX)) ? (cnt + CNT_ONE) : cnt;
  endfunction

  // Scoreboard entries. Only the EX copy of is_load feeds a decision, so the
  // later stages keep just what the match rule needs.
  logic                      ex_valid_r, ex_regwrite_r, ex_is_load_r;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_r, ex_rs1_r, ex_rs2_r;
  logic                      ex_use_rs1_r, ex_use_rs2_r;
  logic                      mem_valid_r, mem_regwrite_r;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_r;
  logic                      wb_valid_r, wb_regwrite_r;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_r;
  logic [CNT_WIDTH-1:0]      retired_cnt_r, stall_cnt_r, flush_cnt_r;

  logic       hazard_s, branch_s, stall_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // Hazard detection, branch qualification and bypass selection.
  always_comb begin
    hazard_s = 1'b0;
    fwd_a_s  = SEL_RF;
    fwd_b_s  = SEL_RF;
    if (FORWARDING) begin
      // Only a load in EX cannot be bypassed in time: one bubble is enough.
      hazard_s = id_valid && ex_is_load_r &&
                 (src_match(ex_valid_r, ex_regwrite_r, ex_rd_r, id_rs1, id_use_rs1) ||
                  src_match(ex_valid_r, ex_regwrite_r, ex_rd_r, id_rs2, id_use_rs2));
      // MEM holds the younger result, so it wins over WB.
      if (src_match(mem_valid_r, mem_regwrite_r, mem_rd_r, ex_rs1_r, ex_use_rs1_r)) begin
        fwd_a_s = SEL_MEM;
      end else if (src_match(wb_valid_r, wb_regwrite_r, wb_rd_r, ex_rs1_r, ex_use_rs1_r)) begin
        fwd_a_s = SEL_WB;
      end else begin
        fwd_a_s = SEL_RF;
      end
      if (src_match(mem_valid_r, mem_regwrite_r, mem_rd_r, ex_rs2_r, ex_use_rs2_r)) begin
        fwd_b_s = SEL_MEM;
      end else if (src_match(wb_valid_r, wb_regwrite_r, wb_rd_r, ex_rs2_r, ex_use_rs2_r)) begin
        fwd_b_s = SEL_WB;
      end else begin
        fwd_b_s = SEL_RF;
      end
    end else begin
      // Without bypass, wait until the producer reaches WB; the register
      // file writes in the first half of the cycle so WB needs no check.
      hazard_s = id_valid &&
                 (src_match(ex_valid_r,  ex_regwrite_r,  ex_rd_r,  id_rs1, id_use_rs1) ||
                  src_match(ex_valid_r,  ex_regwrite_r,  ex_rd_r,  id_rs2, id_use_rs2) ||
                  src_match(mem_valid_r, mem_regwrite_r, mem_rd_r, id_rs1, id_use_rs1) ||
                  src_match(mem_valid_r, mem_regwrite_r, mem_rd_r, id_rs2, id_use_rs2));
    end
    branch_s = ex_branch_taken && ex_valid_r;
    // A taken branch squashes the stalled instruction anyway.
    stall_s  = hazard_s && !branch_s;
  end

  assign stall_f     = stall_s;
  assign stall_d     = stall_s;
  assign flush_d     = branch_s;
  assign flush_e     = branch_s || stall_s;
  assign fwd_a_e     = fwd_a_s;
  assign fwd_b_e     = fwd_b_s;
  assign retired_cnt = retired_cnt_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

  // Scoreboard shift: ID -> EX (or bubble) -> MEM -> WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r     <= 1'b0;
      ex_regwrite_r  <= 1'b0;
      ex_is_load_r   <= 1'b0;
      ex_rd_r        <= REG_X0;
      ex_rs1_r       <= REG_X0;
      ex_rs2_r       <= REG_X0;
      ex_use_rs1_r   <= 1'b0;
      ex_use_rs2_r   <= 1'b0;
      mem_valid_r    <= 1'b0;
      mem_regwrite_r <= 1'b0;
      mem_rd_r       <= REG_X0;
      wb_valid_r     <= 1'b0;
      wb_regwrite_r  <= 1'b0;
      wb_rd_r        <= REG_X0;
    end else begin
      wb_valid_r     <= mem_valid_r;
      wb_regwrite_r  <= mem_regwrite_r;
      wb_rd_r        <= mem_rd_r;
      mem_valid_r    <= ex_valid_r;
      mem_regwrite_r <= ex_regwrite_r;
      mem_rd_r       <= ex_rd_r;
      if (flush_e) begin
        ex_valid_r    <= 1'b0;
        ex_regwrite_r <= 1'b0;
        ex_is_load_r  <= 1'b0;
        ex_rd_r       <= REG_X0;
        ex_rs1_r      <= REG_X0;
        ex_rs2_r      <= REG_X0;
        ex_use_rs1_r  <= 1'b0;
        ex_use_rs2_r  <= 1'b0;
      end else begin
        ex_valid_r    <= id_valid;
        ex_regwrite_r <= id_regwrite;
        ex_is_load_r  <= id_is_load;
        ex_rd_r       <= id_rd;
        ex_rs1_r      <= id_rs1;
        ex_rs2_r      <= id_rs2;
        ex_use_rs1_r  <= id_use_rs1;
        ex_use_rs2_r  <= id_use_rs2;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt_r <= CNT_ZERO;
      stall_cnt_r   <= CNT_ZERO;
      flush_cnt_r   <= CNT_ZERO;
    end else begin
      retired_cnt_r <= sat_inc(retired_cnt_r, wb_valid_r);
      stall_cnt_r   <= sat_inc(stall_cnt_r, stall_s);
      flush_cnt_r   <= sat_inc(flush_cnt_r, branch_s);
    end
  end

endmodule
